rob_commit_ctrl: RTL and testbench
==================================

Name: rob_commit_ctrl

Overview:
Reorder-buffer controller that sequences the register file. It allocates ROB ids at issue and drives the register file's dependency-update port (chg_dependency/chg_rs1/dependent_rob_id). It absorbs CDB writebacks and answers decoder operand queries by ROB id. It retires in order, one entry per cycle, through the register file's commit port (is_commit/commit_rd/commit_data/commit_rob_id) and raises rollback on a mispredicted branch.

Parameters:
ROB_SZ, 16, entry count; power of two.
ROB_ID_W, 4, log2(ROB_SZ); width of ROB ids.
DATA_W, 32, register data width.
REG_ID_W, 5, architectural register index width.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
rdy  in  1  global enable; when low, all state holds and pulse outputs are 0
issue_valid  in  1  decoder presents an instruction
issue_has_rd  in  1  instruction writes rd
issue_rd  in  REG_ID_W  destination register
issue_is_branch  in  1  entry may mispredict
issue_ready  out  1  ROB can accept this cycle
issue_rob_id  out  ROB_ID_W  id given to the accepted instruction (= tail)
chg_dependency  out  1  regfile rename request
chg_rs1  out  REG_ID_W  register being renamed
dependent_rob_id  out  ROB_ID_W  new producer id
cdb_valid  in  1  result broadcast
cdb_rob_id  in  ROB_ID_W  producing entry
cdb_data  in  DATA_W  result value
cdb_mispredict  in  1  branch outcome differs from prediction
cdb_target_pc  in  32  correct PC for a mispredict
q1_rob_id, q2_rob_id  in  ROB_ID_W  operand lookups
q1_ready, q2_ready  out  1  entry has its value
q1_data, q2_data  out  DATA_W  entry value
is_commit  out  1  retire pulse to regfile
commit_rd  out  REG_ID_W  retired destination
commit_data  out  DATA_W  retired value
commit_rob_id  out  ROB_ID_W  retired id
rollback  out  1  flush pulse
redirect_pc  out  32  fetch redirect target

Behaviour:
- Storage per entry: valid, ready, has_rd, rd, data, is_branch, mispredict, target_pc. Pointers: head, tail (ROB_ID_W, wrap modulo ROB_SZ), count (ROB_ID_W+1).
- Reset (async): head=tail=count=0; all valid/ready=0; is_commit=rollback=0; commit_rd/commit_data/commit_rob_id/redirect_pc=0; state=RUN.
- States: RUN and FLUSH. RUN→FLUSH when a mispredicted head retires. FLUSH→RUN after exactly one cycle.
- issue_ready = (state==RUN) & (count<ROB_SZ). There is no bypass: a commit in the same cycle does not make a full ROB ready.
- Accept = issue_valid & issue_ready & rdy. On accept: the entry at tail is written with valid=1 and ready=0, and tail is incremented.
- chg_dependency is combinational: accept & issue_has_rd & (issue_rd!=0). chg_rs1=issue_rd; dependent_rob_id=tail.
- Writeback: on cdb_valid, if the entry is valid, set ready=1 and latch data, mispredict and target_pc. A CDB aimed at an invalid entry is ignored. CDB is ignored in FLUSH.
- Query (combinational): qN_ready = entry.ready | (cdb_valid & cdb_rob_id==qN_rob_id & entry.valid). In the CDB-bypass case qN_data = cdb_data.
- Commit (registered, 1 cycle after head becomes ready; max one per cycle):
  - In RUN, if count>0 and head.ready: is_commit=head.has_rd & rd!=0, and commit_* carry head's fields.
  - The head is cleared and head is incremented. If no accept occurs in the same cycle, count is decremented.
  - A simultaneous accept and commit leaves count unchanged.
- A CDB write to the head in cycle N makes it eligible in N+1, so is_commit is visible in N+2.
- Mispredict: if the retiring head has is_branch & mispredict, then in the same registered update:
  - the normal commit pulse is issued (JAL-style rd writes still commit);
  - rollback=1 and redirect_pc=target_pc;
  - all valid bits are cleared, head=tail=0, count=0, state=FLUSH;
  - any accept in that cycle is discarded.
- In FLUSH: issue_ready=0, no commit, rollback=0 again the following cycle.
- rdy low: no pointer, entry or state change; is_commit/rollback forced 0.
- Reset mid-operation drops all entries immediately.

Decomposition:
- Shared const header (`const.v`): ROB_SZ, ROB_ID_WID, DATA_WID, REG_ID_WID macros; FSM state encodings.
- Optional sub-module rob_entry_ram (entry array + two query read ports + CDB bypass). Pointer/FSM logic stays in rob_commit_ctrl.

Test Plan:
- Reset, then issue rd=5 ×3 → ids 0,1,2; chg_dependency each cycle with dependent_rob_id 0,1,2; count=3.
- CDB id1 data=0xAA then id0 data=0x11 → commits id0 (rd5,0x11) then id1 (0xAA) on consecutive cycles; id2 not committed.
- Fill 16 entries → issue_ready=0; retire one with a simultaneous issue → not accepted that cycle, accepted next, tail wraps to 0.
- q1_rob_id=3 while CDB hits id3 data=0x55 → q1_ready=1, q1_data=0x55 same cycle.
- Branch head mispredict target=0x100 with 4 younger entries → rollback=1 for one cycle, redirect_pc=0x100, count=0, issue_ready=0 one cycle then 1, next issue gets id 0.
- Assert rst asynchronously mid-commit → is_commit drops without a clock edge; all outputs 0.

Source files
------------

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared sizes, FSM states and the per-entry record of the reorder buffer.
package rob_commit_ctrl_pkg;

  localparam int unsigned ROB_SZ   = 16;
  localparam int unsigned ROB_ID_W = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_ID_W = 5;
  localparam int unsigned PC_W     = 32;
  localparam int unsigned CNT_W    = ROB_ID_W + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rob_state_e;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic                has_rd;
    logic [REG_ID_W-1:0] rd;
    logic [DATA_W-1:0]   data;
    logic                is_branch;
    logic                mispredict;
    logic [PC_W-1:0]     target_pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_ctrl_entry_ram.sv
// ROB entry storage: allocate, CDB writeback, head clear, flush, and two
// operand query ports with same-cycle CDB bypass.
module rob_commit_ctrl_entry_ram
  import rob_commit_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_en_i,
  input  logic [ROB_ID_W-1:0] alloc_idx_i,
  input  logic                alloc_has_rd_i,
  input  logic [REG_ID_W-1:0] alloc_rd_i,
  input  logic                alloc_is_branch_i,
  input  logic                cdb_we_i,
  input  logic                cdb_valid_i,
  input  logic [ROB_ID_W-1:0] cdb_idx_i,
  input  logic [DATA_W-1:0]   cdb_data_i,
  input  logic                cdb_mispredict_i,
  input  logic [PC_W-1:0]     cdb_target_pc_i,
  input  logic                clr_en_i,
  input  logic [ROB_ID_W-1:0] clr_idx_i,
  input  logic                flush_i,
  input  logic [ROB_ID_W-1:0] head_idx_i,
  output rob_entry_t          head_o,
  input  logic [ROB_ID_W-1:0] q1_idx_i,
  input  logic [ROB_ID_W-1:0] q2_idx_i,
  output logic                q1_ready_o,
  output logic [DATA_W-1:0]   q1_data_o,
  output logic                q2_ready_o,
  output logic [DATA_W-1:0]   q2_data_o
);

  rob_entry_t mem_q [ROB_SZ];
  rob_entry_t mem_d [ROB_SZ];
  logic       q1_byp, q2_byp;

  // Flush dominates; otherwise allocate, writeback, then retire-clear.
  always_comb begin
    mem_d = mem_q;
    if (flush_i) begin
      for (int unsigned i = 0; i < ROB_SZ; i++) begin
        mem_d[i].valid = 1'b0;
        mem_d[i].ready = 1'b0;
      end
    end else begin
      if (alloc_en_i) begin
        mem_d[alloc_idx_i].valid      = 1'b1;
        mem_d[alloc_idx_i].ready      = 1'b0;
        mem_d[alloc_idx_i].has_rd     = alloc_has_rd_i;
        mem_d[alloc_idx_i].rd         = alloc_rd_i;
        mem_d[alloc_idx_i].data       = '0;
        mem_d[alloc_idx_i].is_branch  = alloc_is_branch_i;
        mem_d[alloc_idx_i].mispredict = 1'b0;
        mem_d[alloc_idx_i].target_pc  = '0;
      end
      if (cdb_we_i && mem_q[cdb_idx_i].valid) begin
        mem_d[cdb_idx_i].ready      = 1'b1;
        mem_d[cdb_idx_i].data       = cdb_data_i;
        mem_d[cdb_idx_i].mispredict = cdb_mispredict_i;
        mem_d[cdb_idx_i].target_pc  = cdb_target_pc_i;
      end
      if (clr_en_i) begin
        mem_d[clr_idx_i].valid = 1'b0;
        mem_d[clr_idx_i].ready = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  assign head_o = mem_q[head_idx_i];

  assign q1_byp     = cdb_valid_i && (cdb_idx_i == q1_idx_i) && mem_q[q1_idx_i].valid;
  assign q2_byp     = cdb_valid_i && (cdb_idx_i == q2_idx_i) && mem_q[q2_idx_i].valid;
  assign q1_ready_o = mem_q[q1_idx_i].ready | q1_byp;
  assign q2_ready_o = mem_q[q2_idx_i].ready | q2_byp;
  assign q1_data_o  = q1_byp ? cdb_data_i : mem_q[q1_idx_i].data;
  assign q2_data_o  = q2_byp ? cdb_data_i : mem_q[q2_idx_i].data;

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer controller: in-order allocation, writeback absorption,
// single-entry retirement into the regfile and mispredict rollback.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                issue_valid,
  input  logic                issue_has_rd,
  input  logic [REG_ID_W-1:0] issue_rd,
  input  logic                issue_is_branch,
  output logic                issue_ready,
  output logic [ROB_ID_W-1:0] issue_rob_id,
  output logic                chg_dependency,
  output logic [REG_ID_W-1:0] chg_rs1,
  output logic [ROB_ID_W-1:0] dependent_rob_id,
  input  logic                cdb_valid,
  input  logic [ROB_ID_W-1:0] cdb_rob_id,
  input  logic [DATA_W-1:0]   cdb_data,
  input  logic                cdb_mispredict,
  input  logic [PC_W-1:0]     cdb_target_pc,
  input  logic [ROB_ID_W-1:0] q1_rob_id,
  input  logic [ROB_ID_W-1:0] q2_rob_id,
  output logic                q1_ready,
  output logic [DATA_W-1:0]   q1_data,
  output logic                q2_ready,
  output logic [DATA_W-1:0]   q2_data,
  output logic                is_commit,
  output logic [REG_ID_W-1:0] commit_rd,
  output logic [DATA_W-1:0]   commit_data,
  output logic [ROB_ID_W-1:0] commit_rob_id,
  output logic                rollback,
  output logic [PC_W-1:0]     redirect_pc
);

  rob_state_e          state_q, state_d;
  logic [ROB_ID_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                is_commit_q, is_commit_d, rollback_q, rollback_d;
  logic [REG_ID_W-1:0] commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0]   commit_data_q, commit_data_d;
  logic [ROB_ID_W-1:0] commit_rob_id_q, commit_rob_id_d;
  logic [PC_W-1:0]     redirect_pc_q, redirect_pc_d;

  rob_entry_t head_e;
  logic       accept, commit_go, flush_go;

  assign issue_ready      = (state_q == ST_RUN) && (count_q < CNT_W'(ROB_SZ));
  assign accept           = issue_valid & issue_ready & rdy;
  assign issue_rob_id     = tail_q;
  assign chg_dependency   = accept & issue_has_rd & (issue_rd != '0);
  assign chg_rs1          = issue_rd;
  assign dependent_rob_id = tail_q;

  assign commit_go = rdy && (state_q == ST_RUN) && (count_q != '0) && head_e.valid && head_e.ready;
  assign flush_go  = commit_go & head_e.is_branch & head_e.mispredict;

  rob_commit_ctrl_entry_ram u_ram (
    .clk               (clk),
    .rst               (rst),
    .alloc_en_i        (accept & ~flush_go),
    .alloc_idx_i       (tail_q),
    .alloc_has_rd_i    (issue_has_rd),
    .alloc_rd_i        (issue_rd),
    .alloc_is_branch_i (issue_is_branch),
    .cdb_we_i          (rdy & (state_q == ST_RUN) & cdb_valid & ~flush_go),
    .cdb_valid_i       (cdb_valid),
    .cdb_idx_i         (cdb_rob_id),
    .cdb_data_i        (cdb_data),
    .cdb_mispredict_i  (cdb_mispredict),
    .cdb_target_pc_i   (cdb_target_pc),
    .clr_en_i          (commit_go & ~flush_go),
    .clr_idx_i         (head_q),
    .flush_i           (flush_go),
    .head_idx_i        (head_q),
    .head_o            (head_e),
    .q1_idx_i          (q1_rob_id),
    .q2_idx_i          (q2_rob_id),
    .q1_ready_o        (q1_ready),
    .q1_data_o         (q1_data),
    .q2_ready_o        (q2_ready),
    .q2_data_o         (q2_data)
  );

  // Pointer, count, FSM and retire-port next state.
  always_comb begin
    state_d         = state_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    is_commit_d     = 1'b0;
    rollback_d      = 1'b0;
    commit_rd_d     = commit_rd_q;
    commit_data_d   = commit_data_q;
    commit_rob_id_d = commit_rob_id_q;
    redirect_pc_d   = redirect_pc_q;
    if (rdy) begin
      case (state_q)
        ST_RUN: begin
          if (commit_go) begin
            is_commit_d     = head_e.has_rd && (head_e.rd != '0);
            commit_rd_d     = head_e.rd;
            commit_data_d   = head_e.data;
            commit_rob_id_d = head_q;
          end
          if (flush_go) begin
            rollback_d    = 1'b1;
            redirect_pc_d = head_e.target_pc;
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            state_d       = ST_FLUSH;
          end else begin
            if (accept)    tail_d = tail_q + ROB_ID_W'(1);
            if (commit_go) head_d = head_q + ROB_ID_W'(1);
            if (accept && !commit_go)      count_d = count_q + CNT_W'(1);
            else if (!accept && commit_go) count_d = count_q - CNT_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_RUN;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      is_commit_q     <= 1'b0;
      rollback_q      <= 1'b0;
      commit_rd_q     <= '0;
      commit_data_q   <= '0;
      commit_rob_id_q <= '0;
      redirect_pc_q   <= '0;
    end else begin
      state_q         <= state_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      is_commit_q     <= is_commit_d;
      rollback_q      <= rollback_d;
      commit_rd_q     <= commit_rd_d;
      commit_data_q   <= commit_data_d;
      commit_rob_id_q <= commit_rob_id_d;
      redirect_pc_q   <= redirect_pc_d;
    end
  end

  assign is_commit     = is_commit_q;
  assign rollback      = rollback_q;
  assign commit_rd     = commit_rd_q;
  assign commit_data   = commit_data_q;
  assign commit_rob_id = commit_rob_id_q;
  assign redirect_pc   = redirect_pc_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: directed scenarios plus random traffic, all
// checked against a FIFO-of-instructions model of the reorder buffer.
module tb_rob_commit_ctrl;

  logic        clk, rst, rdy;
  logic        issue_valid, issue_has_rd, issue_is_branch;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [3:0]  issue_rob_id;
  logic        chg_dependency;
  logic [4:0]  chg_rs1;
  logic [3:0]  dependent_rob_id;
  logic        cdb_valid, cdb_mispredict;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_data, cdb_target_pc;
  logic [3:0]  q1_rob_id, q2_rob_id;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic        is_commit, rollback;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data, redirect_pc;
  logic [3:0]  commit_rob_id;

  rob_commit_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
    .issue_is_branch(issue_is_branch), .issue_ready(issue_ready), .issue_rob_id(issue_rob_id),
    .chg_dependency(chg_dependency), .chg_rs1(chg_rs1), .dependent_rob_id(dependent_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict), .cdb_target_pc(cdb_target_pc),
    .q1_rob_id(q1_rob_id), .q2_rob_id(q2_rob_id), .q1_ready(q1_ready), .q1_data(q1_data),
    .q2_ready(q2_ready), .q2_data(q2_data),
    .is_commit(is_commit), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_rob_id(commit_rob_id), .rollback(rollback), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          rdy;
    bit          has_rd;
    int          rd;
    logic [31:0] data;
    bit          br;
    bit          misp;
    logic [31:0] tpc;
  } ment_t;

  ment_t       mq[$];
  int          next_id;
  bit          m_flush;
  bit          e_is_commit, e_rollback;
  int          e_commit_rd, e_commit_id;
  logic [31:0] e_commit_data, e_redirect;
  int          n_cmp, n_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_idx(input int id);
    foreach (mq[i]) if (mq[i].id == id) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    next_id = 0; m_flush = 0;
    e_is_commit = 0; e_rollback = 0;
    e_commit_rd = 0; e_commit_id = 0; e_commit_data = '0; e_redirect = '0;
  endtask

  task automatic set_idle();
    rdy = 1'b1; issue_valid = 1'b0; issue_has_rd = 1'b0; issue_rd = '0; issue_is_branch = 1'b0;
    cdb_valid = 1'b0; cdb_rob_id = '0; cdb_data = '0; cdb_mispredict = 1'b0; cdb_target_pc = '0;
    q1_rob_id = '0; q2_rob_id = '0;
  endtask

  task automatic check_query(input string tag, input int qid, input logic got_rdy, input logic [31:0] got_data);
    int k;
    bit byp, er;
    k   = find_idx(qid);
    byp = cdb_valid && (int'(cdb_rob_id) == qid) && (k >= 0);
    er  = byp || ((k >= 0) && mq[k].rdy);
    check_eq({tag, "_ready"}, got_rdy, er);
    if (er) check_eq({tag, "_data"}, got_data, byp ? cdb_data : mq[k].data);
  endtask

  task automatic check_comb();
    bit er, acc, chg;
    er  = !m_flush && (mq.size() < 16);
    acc = issue_valid && er && rdy;
    chg = acc && issue_has_rd && (issue_rd != 0);
    check_eq("issue_ready", issue_ready, er);
    check_eq("issue_rob_id", issue_rob_id, next_id);
    check_eq("chg_dependency", chg_dependency, chg);
    if (chg) begin
      check_eq("chg_rs1", chg_rs1, issue_rd);
      check_eq("dependent_rob_id", dependent_rob_id, next_id);
    end
    check_query("q1", int'(q1_rob_id), q1_ready, q1_data);
    check_query("q2", int'(q2_rob_id), q2_ready, q2_data);
  endtask

  // Advance the reference ROB by one clock using the inputs now applied.
  task automatic model_step();
    bit    acc;
    int    k;
    ment_t h, n;
    acc = issue_valid && rdy && !m_flush && (mq.size() < 16);
    e_is_commit = 0;
    e_rollback  = 0;
    if (!rdy) return;
    if (m_flush) begin
      m_flush = 0;
      return;
    end
    if (mq.size() > 0 && mq[0].rdy) begin
      h = mq.pop_front();
      e_is_commit   = h.has_rd && (h.rd != 0);
      e_commit_rd   = h.rd;
      e_commit_data = h.data;
      e_commit_id   = h.id;
      if (h.br && h.misp) begin
        e_rollback = 1;
        e_redirect = h.tpc;
        mq.delete();
        next_id = 0;
        m_flush = 1;
        return;
      end
    end
    if (cdb_valid) begin
      k = find_idx(int'(cdb_rob_id));
      if (k >= 0) begin
        mq[k].rdy  = 1;
        mq[k].data = cdb_data;
        mq[k].misp = cdb_mispredict;
        mq[k].tpc  = cdb_target_pc;
      end
    end
    if (acc) begin
      n.id = next_id; n.rdy = 0; n.has_rd = issue_has_rd; n.rd = int'(issue_rd);
      n.data = '0; n.br = issue_is_branch; n.misp = 0; n.tpc = '0;
      mq.push_back(n);
      next_id = (next_id + 1) % 16;
    end
  endtask

  task automatic check_regs();
    check_eq("is_commit", is_commit, e_is_commit);
    check_eq("rollback", rollback, e_rollback);
    check_eq("commit_rd", commit_rd, e_commit_rd);
    check_eq("commit_data", commit_data, e_commit_data);
    check_eq("commit_rob_id", commit_rob_id, e_commit_id);
    check_eq("redirect_pc", redirect_pc, e_redirect);
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge.
  task automatic tick();
    #1;
    check_comb();
    model_step();
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic do_issue(input bit has_rd, input int rd, input bit br);
    set_idle();
    issue_valid = 1'b1; issue_has_rd = has_rd; issue_rd = 5'(rd); issue_is_branch = br;
  endtask

  task automatic do_cdb(input int id, input logic [31:0] d, input bit misp, input logic [31:0] tpc);
    set_idle();
    cdb_valid = 1'b1; cdb_rob_id = 4'(id); cdb_data = d; cdb_mispredict = misp; cdb_target_pc = tpc;
  endtask

  task automatic randomize_inputs();
    rdy             = ($urandom_range(0, 9) != 0);
    issue_valid     = ($urandom_range(0, 9) < 6);
    issue_has_rd    = 1'($urandom);
    issue_rd        = 5'($urandom_range(0, 31));
    issue_is_branch = ($urandom_range(0, 4) == 0);
    cdb_valid       = 1'($urandom);
    if (mq.size() > 0 && $urandom_range(0, 3) != 0)
      cdb_rob_id = 4'(mq[$urandom_range(0, mq.size() - 1)].id);
    else
      cdb_rob_id = 4'($urandom_range(0, 15));
    cdb_data       = $urandom;
    cdb_mispredict = ($urandom_range(0, 7) == 0);
    cdb_target_pc  = $urandom;
    if (mq.size() > 0 && $urandom_range(0, 1) != 0)
      q1_rob_id = 4'(mq[$urandom_range(0, mq.size() - 1)].id);
    else
      q1_rob_id = 4'($urandom_range(0, 15));
    q2_rob_id = (cdb_valid && $urandom_range(0, 2) == 0) ? cdb_rob_id : 4'($urandom_range(0, 15));
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_regs();
    check_eq("rst_issue_ready", issue_ready, 1'b1);
    check_eq("rst_issue_rob_id", issue_rob_id, 0);
    rst = 1'b0;

    // Three renames of x5 take ids 0,1,2.
    for (int i = 0; i < 3; i++) begin
      do_issue(1, 5, 0);
      check_eq("plan_id", issue_rob_id, i);
      tick();
    end

    // Out-of-order writeback, in-order retirement.
    do_cdb(1, 32'hAA, 0, '0); tick();
    do_cdb(0, 32'h11, 0, '0); tick();
    set_idle(); tick();
    check_eq("plan_c0_data", commit_data, 32'h11);
    check_eq("plan_c0_id", commit_rob_id, 0);
    set_idle(); tick();
    check_eq("plan_c1_data", commit_data, 32'hAA);
    check_eq("plan_c1_id", commit_rob_id, 1);
    set_idle(); tick();

    // Fill to capacity; the last attempt is refused.
    for (int i = 0; i < 16; i++) begin
      do_issue(1, 7, 0);
      tick();
    end
    check_eq("full_not_ready", issue_ready, 1'b0);

    // Same-cycle CDB bypass on a query port.
    do_cdb(3, 32'h55, 0, '0);
    q1_rob_id = 4'd3;
    #1;
    check_eq("byp_q1_ready", q1_ready, 1'b1);
    check_eq("byp_q1_data", q1_data, 32'h55);
    tick();

    // Retire from full with an issue in the same cycle: issue is refused.
    do_cdb(2, 32'h22, 0, '0); tick();
    do_issue(1, 9, 0); tick();
    check_eq("post_commit_ready", issue_ready, 1'b1);
    do_issue(1, 9, 0); tick();

    // Asynchronous reset while a commit pulse is showing.
    check_eq("pre_rst_commit", is_commit, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_regs();
    check_eq("mid_rst_issue_ready", issue_ready, 1'b1);
    check_eq("mid_rst_issue_rob_id", issue_rob_id, 0);
    @(negedge clk);
    rst = 1'b0;

    // Mispredicted branch at the head with four younger entries.
    do_issue(1, 1, 1); tick();
    for (int i = 0; i < 4; i++) begin
      do_issue(1, 2 + i, 0); tick();
    end
    do_cdb(0, 32'h4, 1, 32'h100); tick();
    set_idle(); tick();
    check_eq("misp_rollback", rollback, 1'b1);
    check_eq("misp_redirect", redirect_pc, 32'h100);
    check_eq("misp_flush_not_ready", issue_ready, 1'b0);
    set_idle(); tick();
    check_eq("misp_rollback_drop", rollback, 1'b0);
    check_eq("misp_ready_again", issue_ready, 1'b1);
    check_eq("misp_next_id", issue_rob_id, 0);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      randomize_inputs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
